// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU op-class encodings and payload types for the ID/EX pipeline register.
package id_ex_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned ALU_OP_W   = 3;
    localparam int unsigned CTRL_W     = 11;

    // ALU op classes produced by the ID control unit
    localparam logic [ALU_OP_W-1:0] ALU_OP_R    = 3'b111;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADDI = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LUI  = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ORI  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ANDI = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LW   = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SW   = 3'b101;

    // Control bundle: eight single-bit controls plus the ALU op class (CTRL_W bits)
    typedef struct packed {
        logic                reg_dst;
        logic                branch_eq;
        logic                branch_ne;
        logic                mem_read;
        logic                mem_to_reg;
        logic                mem_write;
        logic                alu_src;
        logic                reg_write;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    // Datapath operands and register specifiers carried alongside the controls
    typedef struct packed {
        logic [DATA_W-1:0]     pc_plus4;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm_ext;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
    } payload_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction in ID.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_addr_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    output logic                  hazard_c_o
);

    logic dest_live_c;
    logic src_match_c;

    // $0 never carries a dependency; rs and rt are both compared for every opcode
    always_comb begin
        dest_live_c = ex_valid_i & ex_mem_read_i & (ex_rt_addr_i != '0);
        src_match_c = (ex_rt_addr_i == id_rs_addr_i) | (ex_rt_addr_i == id_rt_addr_i);
        hazard_c_o  = dest_live_c & id_valid_i & src_match_c;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/hold/load-use bubble insertion and a bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_dst_i,
    input  logic                  branch_eq_i,
    input  logic                  branch_ne_i,
    input  logic                  mem_read_i,
    input  logic                  mem_to_reg_i,
    input  logic                  mem_write_i,
    input  logic                  alu_src_i,
    input  logic                  reg_write_i,
    input  logic [ALU_OP_W-1:0]   alu_op_i,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     pc_plus4_i,
    input  logic [DATA_W-1:0]     rs_data_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [DATA_W-1:0]     imm_ext_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  flush_i,
    input  logic                  hold_i,
    output logic                  reg_dst_o,
    output logic                  branch_eq_o,
    output logic                  branch_ne_o,
    output logic                  mem_read_o,
    output logic                  mem_to_reg_o,
    output logic                  mem_write_o,
    output logic                  alu_src_o,
    output logic                  reg_write_o,
    output logic [ALU_OP_W-1:0]   alu_op_o,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     pc_plus4_o,
    output logic [DATA_W-1:0]     rs_data_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [DATA_W-1:0]     imm_ext_o,
    output logic [REG_ADDR_W-1:0] rs_addr_o,
    output logic [REG_ADDR_W-1:0] rt_addr_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    ctrl_t            ctrl_q,       ctrl_d;
    logic             valid_q,      valid_d;
    payload_t         payload_q,    payload_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    ctrl_t            ctrl_in_c;
    payload_t         payload_in_c;
    logic             stall_c;

    // Pack the incoming ID fields into the bus payload types
    always_comb begin
        ctrl_in_c.reg_dst    = reg_dst_i;
        ctrl_in_c.branch_eq  = branch_eq_i;
        ctrl_in_c.branch_ne  = branch_ne_i;
        ctrl_in_c.mem_read   = mem_read_i;
        ctrl_in_c.mem_to_reg = mem_to_reg_i;
        ctrl_in_c.mem_write  = mem_write_i;
        ctrl_in_c.alu_src    = alu_src_i;
        ctrl_in_c.reg_write  = reg_write_i;
        ctrl_in_c.alu_op     = alu_op_i;

        payload_in_c.pc_plus4 = pc_plus4_i;
        payload_in_c.rs_data  = rs_data_i;
        payload_in_c.rt_data  = rt_data_i;
        payload_in_c.imm_ext  = imm_ext_i;
        payload_in_c.rs_addr  = rs_addr_i;
        payload_in_c.rt_addr  = rt_addr_i;
        payload_in_c.rd_addr  = rd_addr_i;
    end

    // Hazard compare sees only registered EX state and ID inputs, never flush/hold
    load_use_detect u_load_use_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rt_addr_i  (payload_q.rt_addr),
        .id_valid_i    (valid_i),
        .id_rs_addr_i  (rs_addr_i),
        .id_rt_addr_i  (rt_addr_i),
        .hazard_c_o    (stall_c)
    );

    // Next-state select: flush > hold > load-use stall > normal load; bubbles keep data fields
    always_comb begin
        ctrl_d       = ctrl_q;
        valid_d      = valid_q;
        payload_d    = payload_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush_i) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (hold_i) begin
            // frozen: everything keeps its value
        end else if (stall_c) begin
            ctrl_d       = '0;
            valid_d      = 1'b0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (!valid_i) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else begin
            ctrl_d    = ctrl_in_c;
            valid_d   = 1'b1;
            payload_d = payload_in_c;
        end
    end

    // Pipeline state; reset clears everything asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q       <= '0;
            valid_q      <= 1'b0;
            payload_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            valid_q      <= valid_d;
            payload_q    <= payload_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Output mapping
    always_comb begin
        reg_dst_o    = ctrl_q.reg_dst;
        branch_eq_o  = ctrl_q.branch_eq;
        branch_ne_o  = ctrl_q.branch_ne;
        mem_read_o   = ctrl_q.mem_read;
        mem_to_reg_o = ctrl_q.mem_to_reg;
        mem_write_o  = ctrl_q.mem_write;
        alu_src_o    = ctrl_q.alu_src;
        reg_write_o  = ctrl_q.reg_write;
        alu_op_o     = ctrl_q.alu_op;
        valid_o      = valid_q;
        pc_plus4_o   = payload_q.pc_plus4;
        rs_data_o    = payload_q.rs_data;
        rt_data_o    = payload_q.rt_data;
        imm_ext_o    = payload_q.imm_ext;
        rs_addr_o    = payload_q.rs_addr;
        rt_addr_o    = payload_q.rt_addr;
        rd_addr_o    = payload_q.rd_addr;
        stall_o      = stall_c;
        bubble_cnt_o = bubble_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use, $0, priority, hold, saturation.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        reg_dst_i, branch_eq_i, branch_ne_i, mem_read_i;
    logic        mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i;
    logic [2:0]  alu_op_i;
    logic        valid_i;
    logic [31:0] pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
    logic        flush_i, hold_i;

    logic        reg_dst_o, branch_eq_o, branch_ne_o, mem_read_o;
    logic        mem_to_reg_o, mem_write_o, alu_src_o, reg_write_o;
    logic [2:0]  alu_op_o;
    logic        valid_o;
    logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o;
    logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
    logic        stall_o;
    logic [15:0] bubble_cnt_o;

    int tests = 0;
    int fails = 0;

    logic [10:0] ctrl_obs;
    assign ctrl_obs = {reg_dst_o, branch_eq_o, branch_ne_o, mem_read_o, mem_to_reg_o,
                       mem_write_o, alu_src_o, reg_write_o, alu_op_o};

    localparam logic [10:0] CTRL_ALL  = 11'h7FF;
    localparam logic [10:0] CTRL_ADDI = 11'h01C;
    localparam logic [10:0] CTRL_LW   = 11'h0DB;
    localparam logic [10:0] CTRL_R    = 11'h40F;

    id_ex_stage dut (
        .clk          (clk),
        .reset        (reset),
        .reg_dst_i    (reg_dst_i),
        .branch_eq_i  (branch_eq_i),
        .branch_ne_i  (branch_ne_i),
        .mem_read_i   (mem_read_i),
        .mem_to_reg_i (mem_to_reg_i),
        .mem_write_i  (mem_write_i),
        .alu_src_i    (alu_src_i),
        .reg_write_i  (reg_write_i),
        .alu_op_i     (alu_op_i),
        .valid_i      (valid_i),
        .pc_plus4_i   (pc_plus4_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .imm_ext_i    (imm_ext_i),
        .rs_addr_i    (rs_addr_i),
        .rt_addr_i    (rt_addr_i),
        .rd_addr_i    (rd_addr_i),
        .flush_i      (flush_i),
        .hold_i       (hold_i),
        .reg_dst_o    (reg_dst_o),
        .branch_eq_o  (branch_eq_o),
        .branch_ne_o  (branch_ne_o),
        .mem_read_o   (mem_read_o),
        .mem_to_reg_o (mem_to_reg_o),
        .mem_write_o  (mem_write_o),
        .alu_src_o    (alu_src_o),
        .reg_write_o  (reg_write_o),
        .alu_op_o     (alu_op_o),
        .valid_o      (valid_o),
        .pc_plus4_o   (pc_plus4_o),
        .rs_data_o    (rs_data_o),
        .rt_data_o    (rt_data_o),
        .imm_ext_o    (imm_ext_o),
        .rs_addr_o    (rs_addr_o),
        .rt_addr_o    (rt_addr_o),
        .rd_addr_o    (rd_addr_o),
        .stall_o      (stall_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        {reg_dst_i, branch_eq_i, branch_ne_i, mem_read_i} = 4'b0000;
        {mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i} = 4'b0000;
        alu_op_i = 3'b000;
        valid_i  = 1'b1;
    endtask

    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
        clear_ctrl();
        alu_op_i = 3'b011; alu_src_i = 1'b1; mem_read_i = 1'b1;
        mem_to_reg_i = 1'b1; reg_write_i = 1'b1;
        rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = 5'd0;
        imm_ext_i = 32'h0000_0010; pc_plus4_i = 32'h0000_0200;
        rs_data_i = 32'h0000_1000; rt_data_i = 32'h0000_2000;
    endtask

    task automatic set_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        clear_ctrl();
        alu_op_i = 3'b100; alu_src_i = 1'b1; reg_write_i = 1'b1;
        rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = 5'd0;
        imm_ext_i = imm; pc_plus4_i = 32'h0000_0100;
        rs_data_i = 32'hAAAA_0001; rt_data_i = 32'hBBBB_0002;
    endtask

    task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_ctrl();
        alu_op_i = 3'b111; reg_dst_i = 1'b1; reg_write_i = 1'b1;
        rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd;
        imm_ext_i = 32'h0000_0000; pc_plus4_i = 32'h0000_0300;
        rs_data_i = 32'hCCCC_0003; rt_data_i = 32'hDDDD_0004;
    endtask

    initial begin
        reset = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
        clear_ctrl(); valid_i = 1'b0;
        pc_plus4_i = '0; rs_data_i = '0; rt_data_i = '0; imm_ext_i = '0;
        rs_addr_i = '0; rt_addr_i = '0; rd_addr_i = '0;
        tick();
        reset = 1'b1;

        // all-nonzero instruction, then reset mid-hazard between edges
        {reg_dst_i, branch_eq_i, branch_ne_i, mem_read_i} = 4'b1111;
        {mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i} = 4'b1111;
        alu_op_i = 3'b111; valid_i = 1'b1;
        pc_plus4_i = 32'h1111_1111; rs_data_i = 32'h2222_2222;
        rt_data_i = 32'h3333_3333; imm_ext_i = 32'h4444_4444;
        rs_addr_i = 5'd1; rt_addr_i = 5'd2; rd_addr_i = 5'd3;
        tick();
        chk("load_all_ctrl", 32'(ctrl_obs), 32'(CTRL_ALL));
        chk("load_all_valid", 32'(valid_o), 32'd1);
        chk("load_all_pc", pc_plus4_o, 32'h1111_1111);
        chk("hazard_rt_match", 32'(stall_o), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_ctrl", 32'(ctrl_obs), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", pc_plus4_o | rs_data_o | rt_data_o | imm_ext_o, 32'd0);
        chk("rst_addr", 32'({rs_addr_o, rt_addr_o, rd_addr_o}), 32'd0);
        chk("rst_cnt", 32'(bubble_cnt_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        #1 reset = 1'b1;
        tick();
        chk("post_rst_load_ctrl", 32'(ctrl_obs), 32'(CTRL_ALL));
        chk("post_rst_load_valid", 32'(valid_o), 32'd1);
        chk("post_rst_cnt", 32'(bubble_cnt_o), 32'd0);
        tick();
        chk("stall1_valid", 32'(valid_o), 32'd0);
        chk("stall1_ctrl", 32'(ctrl_obs), 32'd0);
        chk("stall1_cnt", 32'(bubble_cnt_o), 32'd1);
        chk("stall1_data_held", pc_plus4_o, 32'h1111_1111);
        chk("stall1_cleared", 32'(stall_o), 32'd0);

        // ADDI pass-through
        set_addi(5'd4, 5'd8, 32'h0000_0005);
        #1 chk("addi_no_stall", 32'(stall_o), 32'd0);
        tick();
        chk("addi_ctrl", 32'(ctrl_obs), 32'(CTRL_ADDI));
        chk("addi_valid", 32'(valid_o), 32'd1);
        chk("addi_imm", imm_ext_o, 32'h0000_0005);
        chk("addi_rt", 32'(rt_addr_o), 32'd8);
        chk("addi_rs", 32'(rs_addr_o), 32'd4);
        chk("addi_pc", pc_plus4_o, 32'h0000_0100);
        chk("addi_rsd", rs_data_o, 32'hAAAA_0001);
        chk("addi_rtd", rt_data_o, 32'hBBBB_0002);
        chk("addi_stall", 32'(stall_o), 32'd0);

        // load-use on rs
        set_lw(5'd2, 5'd9);
        #1 chk("lw_after_addi_no_stall", 32'(stall_o), 32'd0);
        tick();
        chk("lw_ctrl", 32'(ctrl_obs), 32'(CTRL_LW));
        set_rtype(5'd9, 5'd10, 5'd11);
        #1 chk("lu_rs_stall", 32'(stall_o), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(valid_o), 32'd0);
        chk("lu_bubble_ctrl", 32'(ctrl_obs), 32'd0);
        chk("lu_bubble_cnt", 32'(bubble_cnt_o), 32'd2);
        chk("lu_bubble_stall_clear", 32'(stall_o), 32'd0);
        tick();
        chk("lu_reload_ctrl", 32'(ctrl_obs), 32'(CTRL_R));
        chk("lu_reload_valid", 32'(valid_o), 32'd1);
        chk("lu_reload_rd", 32'(rd_addr_o), 32'd11);
        chk("lu_reload_cnt", 32'(bubble_cnt_o), 32'd2);

        // load-use on rt, and valid_i gating
        set_lw(5'd1, 5'd12);
        tick();
        set_rtype(5'd1, 5'd12, 5'd3);
        #1 chk("lu_rt_stall", 32'(stall_o), 32'd1);
        valid_i = 1'b0;
        #1 chk("lu_id_invalid", 32'(stall_o), 32'd0);
        valid_i = 1'b1;

        // flush beats hold and stall; stall_o independent of flush/hold
        flush_i = 1'b1; hold_i = 1'b1;
        #1 chk("prio_stall_visible", 32'(stall_o), 32'd1);
        tick();
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_ctrl", 32'(ctrl_obs), 32'd0);
        chk("flush_cnt", 32'(bubble_cnt_o), 32'd2);
        flush_i = 1'b0; hold_i = 1'b0;

        // hold freezes outputs for three edges
        set_addi(5'd5, 5'd6, 32'h1234_5678);
        tick();
        hold_i = 1'b1;
        set_rtype(5'd7, 5'd7, 5'd7);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_ctrl", 32'(ctrl_obs), 32'(CTRL_ADDI));
            chk("hold_imm", imm_ext_o, 32'h1234_5678);
            chk("hold_rt", 32'(rt_addr_o), 32'd6);
        end
        hold_i = 1'b0;

        // hold while a hazard is pending: no bubble, no count
        set_lw(5'd0, 5'd13);
        tick();
        set_rtype(5'd13, 5'd1, 5'd2);
        hold_i = 1'b1;
        #1 chk("hold_hazard_stall", 32'(stall_o), 32'd1);
        tick();
        chk("hold_hazard_ctrl", 32'(ctrl_obs), 32'(CTRL_LW));
        chk("hold_hazard_cnt", 32'(bubble_cnt_o), 32'd2);
        hold_i = 1'b0;
        tick();
        chk("release_stall_cnt", 32'(bubble_cnt_o), 32'd3);
        chk("release_stall_valid", 32'(valid_o), 32'd0);

        // valid_i=0 loads an uncounted bubble
        set_addi(5'd1, 5'd2, 32'h0000_0077);
        tick();
        valid_i = 1'b0;
        tick();
        chk("invalid_valid", 32'(valid_o), 32'd0);
        chk("invalid_ctrl", 32'(ctrl_obs), 32'd0);
        chk("invalid_cnt", 32'(bubble_cnt_o), 32'd3);
        chk("invalid_imm_held", imm_ext_o, 32'h0000_0077);

        // $0 destination never stalls
        set_lw(5'd3, 5'd0);
        tick();
        set_rtype(5'd0, 5'd0, 5'd4);
        #1 chk("zero_reg_stall", 32'(stall_o), 32'd0);
        tick();
        chk("zero_reg_load", 32'(ctrl_obs), 32'(CTRL_R));
        chk("zero_reg_cnt", 32'(bubble_cnt_o), 32'd3);

        // saturation from a preloaded count
        force dut.bubble_cnt_q = 16'hFFFD;
        #1 release dut.bubble_cnt_q;
        for (int k = 0; k < 3; k++) begin
            set_lw(5'd0, 5'd14);
            tick();
            set_rtype(5'd14, 5'd1, 5'd2);
            #1 chk("sat_stall", 32'(stall_o), 32'd1);
            tick();
            chk("sat_cnt", 32'(bubble_cnt_o), (k == 0) ? 32'h0000_FFFE : 32'h0000_FFFF);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL provide: clk  in  1  single clock, rising-edge; all state in this domain.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: reg_dst_i, branch_eq_i, branch_ne_i, mem_read_i, mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i  in  1 each  decoded control from the ID-stage control unit.
REQ-004 SHALL provide: alu_op_i  in  3  ALU op class (R=111, ADDI=100, LUI=000, ORI=001, ANDI=010, LW=011, SW=101).
REQ-005 SHALL provide: valid_i  in  1  ID holds a real instruction.
REQ-006 SHALL provide: pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i  in  32 each  ID datapath operands.
REQ-007 SHALL provide: rs_addr_i, rt_addr_i, rd_addr_i  in  5 each  register specifiers.
REQ-008 SHALL provide: flush_i  in  1  squash ID instruction (taken branch); hold_i  in  1  downstream freeze.
REQ-009 SHALL provide: matching registered outputs *_o for every REQ-003..007 signal, same widths.
REQ-010 SHALL provide: stall_o  out  1  load-use hazard, upstream (PC, IF/ID) SHALL hold.
REQ-011 SHALL provide: bubble_cnt_o  out  16  count of hazard bubbles inserted.

Function
REQ-012 SHALL be a one-cycle pipeline register: under normal load, *_o equal the *_i values sampled at the previous rising edge.
REQ-013 Control bundle = 8 single-bit controls + alu_op (11 bits) + valid; a "bubble" SHALL load the bundle as all-zero, data fields as don't-care but implemented as held.
REQ-014 stall_o SHALL be combinational: 1 iff valid_o & mem_read_o & valid_i & rt_addr_o != 0 & (rt_addr_o == rs_addr_i | rt_addr_o == rt_addr_i).
REQ-015 Rs and rt SHALL both be compared regardless of instruction type (conservative).
REQ-016 Per-edge priority: flush_i > hold_i > stall_o > normal load.
REQ-017 flush_i=1: load bubble, regardless of hold_i or stall_o.
REQ-018 hold_i=1 (flush_i=0): all registers keep value; stall_o still evaluated from held state.
REQ-019 stall_o=1 (flush_i=0, hold_i=0): load bubble; the same ID instruction is re-presented next cycle and the hazard clears since valid_o is then 0.
REQ-020 valid_i=0 under normal load SHALL load a bubble.
REQ-021 bubble_cnt_o SHALL increment by 1 on every edge where REQ-019 applies, saturating at 16'hFFFF; flush and valid_i=0 bubbles SHALL NOT count.
REQ-022 No output SHALL depend combinationally on flush_i or hold_i.

Reset
REQ-023 reset=0 SHALL immediately clear all control outputs, valid_o, alu_op_o, all data/address outputs and bubble_cnt_o to 0, independent of clk.
REQ-024 After reset, stall_o SHALL be 0 (valid_o=0).
REQ-025 Reset asserted mid-hazard SHALL abort the bubble; first edge after deassertion SHALL perform normal load.

Structure
REQ-026 Shared package SHALL hold: control bundle width (11), alu_op encodings of REQ-004, register address width (5), data width (32), counter width (16).
REQ-027 Hazard compare of REQ-014 SHALL be a sub-module load_use_detect (pure combinational); all registers stay in id_ex_stage.

Verification
REQ-028 Reset: drive all inputs nonzero, reset=0 between edges -> all outputs 0 without a clock edge.
REQ-029 Pass-through: ADDI (alu_op 100, alu_src=1, reg_write=1, imm 0x0000_0005, rt=8) -> identical on *_o one edge later, stall_o=0.
REQ-030 Load-use: LW rt=9 in EX, ID R-type rs=9 -> stall_o=1, next edge valid_o=0 and controls 0, bubble_cnt_o=1, following edge R-type loads, stall_o=0.
REQ-031 $0 exemption: LW rt=0 in EX, ID rs=0 -> stall_o=0, normal load.
REQ-032 Priority: flush_i=1 with hold_i=1 and stall_o=1 -> bubble loaded, bubble_cnt_o unchanged; hold_i=1 alone -> outputs frozen 3 cycles.
REQ-033 Saturation: preload 65535 hazard stalls -> bubble_cnt_o=16'hFFFF, stays after further stall.
